// File: rtl/alu_op_scheduler.sv
// Round-robin sequencer for the shared 4-bit ALU: grants one requester, holds operands, captures result.
// Latency: ack pulses SETTLE_CYCLES+1 cycles after the grant edge; one operation per SETTLE_CYCLES+3 cycles.
// Backpressure: requesters hold req until their ack; grants are only taken in IDLE, so DONE is a bubble.
module alu_op_scheduler #(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       a0,
    input  logic [3:0]       b0,
    input  logic [3:0]       a1,
    input  logic [3:0]       b1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    output logic             ack0,
    output logic             ack1,
    output logic [3:0]       rsp_data,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [3:0]       alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     next_state;
    logic [3:0] settle_cnt;
    logic       owner;
    logic       rr_ptr;
    logic       grant_vld;
    logic       grant_id;
    logic       settle_done;

    // On a tie the pointer picks; a lone requester always wins regardless of the pointer.
    assign grant_vld   = req0 | req1;
    assign grant_id    = (req0 & req1) ? rr_ptr : req1;
    assign settle_done = (settle_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant_vld)   next_state = SETTLE;
            SETTLE:  if (settle_done) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        ack0 = (state == DONE) && !owner;
        ack1 = (state == DONE) &&  owner;
    end

    // ALU inputs only change on a grant, so the mux tree sees no activity while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_sel    <= 3'd0;
            rsp_data   <= 4'd0;
            op_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner      <= grant_id;
                        rr_ptr     <= ~grant_id;
                        settle_cnt <= SETTLE_INIT;
                        alu_a      <= grant_id ? a1  : a0;
                        alu_b      <= grant_id ? b1  : b0;
                        alu_sel    <= grant_id ? op1 : op0;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        rsp_data <= alu_result;
                        op_count <= op_count + CNT_W'(1);
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: default build plus a SETTLE_CYCLES=0 / CNT_W=2 build.
module tb_alu_op_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return ~(a & b);
            default: return b;
        endcase
    endfunction

    // default build
    logic       req0 = 0, req1 = 0;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [2:0] op0 = 0, op1 = 0;
    logic       ack0, ack1, busy;
    logic [3:0] rsp_data, alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic [7:0] op_count;
    assign alu_result = alu_f(alu_a, alu_b, alu_sel);

    alu_op_scheduler dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .ack0(ack0), .ack1(ack1), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .busy(busy), .op_count(op_count)
    );

    // zero-settle, narrow-counter build
    logic       zreq0 = 0, zreq1 = 0;
    logic [3:0] za0 = 0, zb0 = 0, za1 = 0, zb1 = 0;
    logic [2:0] zop0 = 0, zop1 = 0;
    logic       zack0, zack1, zbusy;
    logic [3:0] zrsp_data, zalu_a, zalu_b, zalu_result;
    logic [2:0] zalu_sel;
    logic [1:0] zop_count;
    assign zalu_result = alu_f(zalu_a, zalu_b, zalu_sel);

    alu_op_scheduler #(.SETTLE_CYCLES(0), .CNT_W(2)) dutz (
        .clk(clk), .rst(rst), .req0(zreq0), .req1(zreq1),
        .a0(za0), .b0(zb0), .a1(za1), .b1(zb1), .op0(zop0), .op1(zop1),
        .ack0(zack0), .ack1(zack1), .rsp_data(zrsp_data),
        .alu_a(zalu_a), .alu_b(zalu_b), .alu_sel(zalu_sel),
        .alu_result(zalu_result), .busy(zbusy), .op_count(zop_count)
    );

    task automatic do_reset;
        rst = 1'b1;
        req0 = 0; req1 = 0; zreq0 = 0; zreq1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Edge index of the next IDLE->SETTLE transition (busy rising).
    task automatic wait_grant(input bit z, output int g);
        logic prev;
        bit   found;
        prev  = z ? zbusy : busy;
        found = 0;
        g     = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if ((z ? zbusy : busy) && !prev) found = 1;
            else prev = z ? zbusy : busy;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL grant_timeout: got no grant in 40 cycles, required a grant (z=%0d)", z);
        end else begin
            g = cyc;
        end
    endtask

    // Cycles from the grant edge until ack is seen; who=2 flags both acks at once.
    task automatic wait_ack(input bit z, output int who, output logic [3:0] data, output int lat);
        bit found;
        found = 0;
        who = -1; data = 4'h0; lat = -1;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk); #1;
            if (z ? (zack0 | zack1) : (ack0 | ack1)) begin
                found = 1;
                lat   = k;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL ack_timeout: got no ack in 20 cycles, required an ack (z=%0d)", z);
        end else begin
            if (z) who = (zack0 && zack1) ? 2 : (zack1 ? 1 : 0);
            else   who = (ack0 && ack1)   ? 2 : (ack1  ? 1 : 0);
            data = z ? zrsp_data : rsp_data;
        end
    endtask

    task automatic wait_op(input bit z, output int g, output int who, output logic [3:0] data, output int lat);
        wait_grant(z, g);
        wait_ack(z, who, data, lat);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({ack0, ack1, busy, rsp_data, alu_a, alu_b, alu_sel, op_count} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", {ack0, ack1, busy, rsp_data, alu_a, alu_b, alu_sel, op_count});
        end
        tests++;
        if ({zack0, zack1, zbusy, zrsp_data, zalu_a, zalu_b, zalu_sel, zop_count} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs_z: got %h, required 0", {zack0, zack1, zbusy, zrsp_data, zalu_a, zalu_b, zalu_sel, zop_count});
        end
        do_reset();
    endtask

    task automatic test_single;
        int g, who, lat;
        logic [3:0] d;
        do_reset();
        a0 = 4'h5; b0 = 4'h3; op0 = 3'b010; req0 = 1;
        wait_grant(0, g);
        tests++;
        if ({alu_a, alu_b, alu_sel} !== {4'h5, 4'h3, 3'd2} || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL single_alu_inputs: got a=%h b=%h sel=%0d ack0=%b, required 5 3 2 0", alu_a, alu_b, alu_sel, ack0);
        end
        wait_ack(0, who, d, lat);
        tests++;
        if (who !== 0 || lat !== 4) begin
            fails++;
            $display("FAIL single_ack: got who=%0d lat=%0d, required who=0 lat=4", who, lat);
        end
        tests++;
        if (d !== 4'h8 || op_count !== 8'd1) begin
            fails++;
            $display("FAIL single_result: got rsp=%h count=%0d, required rsp=8 count=1", d, op_count);
        end
        req0 = 0;
        @(posedge clk); #1;
        tests++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || rsp_data !== 4'h8) begin
            fails++;
            $display("FAIL single_after: got ack0=%b busy=%b rsp=%h, required 0 0 8", ack0, busy, rsp_data);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || ack1 !== 1'b0 || {alu_a, alu_b, alu_sel} !== {4'h5, 4'h3, 3'd2}) begin
            fails++;
            $display("FAIL single_idle_hold: got busy=%b ack1=%b a=%h b=%h sel=%0d, required 0 0 5 3 2", busy, ack1, alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_round_robin;
        int g1, g2, g3, g4, w1, w2, w3, w4, lat;
        logic [3:0] d1, d2, d3, d4;
        do_reset();
        a0 = 4'h1; b0 = 4'h2; op0 = 3'd2;
        a1 = 4'h7; b1 = 4'h1; op1 = 3'd3;
        req0 = 1; req1 = 1;
        wait_op(0, g1, w1, d1, lat);
        req0 = 0;
        wait_op(0, g2, w2, d2, lat);
        req0 = 1;
        wait_op(0, g3, w3, d3, lat);
        wait_op(0, g4, w4, d4, lat);
        req0 = 0; req1 = 0;
        tests++;
        if (w1 !== 0 || w2 !== 1 || w3 !== 0 || w4 !== 1) begin
            fails++;
            $display("FAIL rr_order: got %0d %0d %0d %0d, required 0 1 0 1", w1, w2, w3, w4);
        end
        tests++;
        if (d1 !== 4'h3 || d2 !== 4'h6 || d3 !== 4'h3 || d4 !== 4'h6) begin
            fails++;
            $display("FAIL rr_data: got %h %h %h %h, required 3 6 3 6", d1, d2, d3, d4);
        end
        tests++;
        if (g2 - g1 !== 6 || g3 - g2 !== 6 || g4 - g3 !== 6) begin
            fails++;
            $display("FAIL rr_spacing: got %0d %0d %0d, required 6 6 6", g2 - g1, g3 - g2, g4 - g3);
        end
    endtask

    task automatic test_back_to_back;
        int g, who, lat, n0, n1;
        logic [3:0] d;
        do_reset();
        a0 = 4'hC; b0 = 4'hA; op0 = 3'd4;
        a1 = 4'hC; b1 = 4'hA; op1 = 3'd0;
        req0 = 1; req1 = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            wait_op(0, g, who, d, lat);
            if (who == 0) n0++;
            if (who == 1) n1++;
            tests++;
            if (who !== (i % 2) || d !== ((i % 2) ? 4'h8 : 4'h6)) begin
                fails++;
                $display("FAIL b2b_op%0d: got who=%0d rsp=%h, required who=%0d rsp=%h", i, who, d, i % 2, (i % 2) ? 4'h8 : 4'h6);
            end
        end
        req0 = 0; req1 = 0;
        tests++;
        if (n0 !== 4 || n1 !== 4 || op_count !== 8'd8) begin
            fails++;
            $display("FAIL b2b_counts: got n0=%0d n1=%0d count=%0d, required 4 4 8", n0, n1, op_count);
        end
    endtask

    task automatic test_reset_midop;
        int g, who, lat;
        bit stray;
        logic [3:0] d;
        do_reset();
        a0 = 4'h5; b0 = 4'h3; op0 = 3'd2; req0 = 1;
        wait_op(0, g, who, d, lat);
        wait_grant(0, g);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({ack0, ack1, busy, rsp_data, alu_a, alu_b, alu_sel, op_count} !== 27'd0) begin
            fails++;
            $display("FAIL midop_reset: got %h, required 0", {ack0, ack1, busy, rsp_data, alu_a, alu_b, alu_sel, op_count});
        end
        req0 = 0; req1 = 1;
        a1 = 4'h9; b1 = 4'h4; op1 = 3'd1;
        stray = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 || ack1 || busy) stray = 1;
        end
        rst = 1'b0;
        tests++;
        if (stray !== 1'b0) begin
            fails++;
            $display("FAIL midop_held: got activity during reset, required none");
        end
        wait_op(0, g, who, d, lat);
        req1 = 0;
        tests++;
        if (who !== 1 || d !== 4'hD || lat !== 4 || op_count !== 8'd1) begin
            fails++;
            $display("FAIL midop_after: got who=%0d rsp=%h lat=%0d count=%0d, required 1 d 4 1", who, d, lat, op_count);
        end
    endtask

    task automatic test_zero_settle_wrap;
        int g, gp, who, lat;
        logic [3:0] d;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        za0 = 4'h2; zb0 = 4'h3; zop0 = 3'd2; zreq0 = 1;
        gp = 0;
        for (int i = 0; i < 5; i++) begin
            wait_op(1, g, who, d, lat);
            tests++;
            if (who !== 0 || lat !== 1 || d !== 4'h5 || zop_count !== exp_cnt[i]) begin
                fails++;
                $display("FAIL zero_op%0d: got who=%0d lat=%0d rsp=%h count=%0d, required 0 1 5 %0d", i, who, lat, d, zop_count, exp_cnt[i]);
            end
            if (i > 0) begin
                tests++;
                if (g - gp !== 3) begin
                    fails++;
                    $display("FAIL zero_spacing%0d: got %0d, required 3", i, g - gp);
                end
            end
            gp = g;
        end
        zreq0 = 0;
        @(posedge clk); #1;
        tests++;
        if (zack0 !== 1'b0 || zbusy !== 1'b0) begin
            fails++;
            $display("FAIL zero_after: got ack0=%b busy=%b, required 0 0", zack0, zbusy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_reset_midop();
        test_zero_settle_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
